// File: rtl/starflux_pkg.sv
// Shared colour constants, default playfield size and scanner state encoding
// for the starflux display path.
package starflux_pkg;

  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] BLUE  = 3'b001;
  localparam logic [2:0] BLACK = 3'b000;

  localparam int DEF_W = 160;
  localparam int DEF_H = 120;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_t;

endpackage

// File: rtl/display_scanner_if.sv
// Game-logic <-> scanner bundle: frame request, ship positions and bullet grid in,
// VGA plot stream and frame status out. The scanner takes the slave side.
interface display_scanner_if #(
  parameter int W  = 160,
  parameter int H  = 120,
  parameter int XW = $clog2(W),
  parameter int YW = $clog2(H)
);

  logic            start;
  logic [XW-1:0]   user_x;
  logic [XW-1:0]   enemy_x;
  logic [W*H-1:0]  grid;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic [2:0]      colour;
  logic            plot;
  logic            busy;
  logic            frame_done;

  modport master (
    output start, user_x, enemy_x, grid,
    input  x, y, colour, plot, busy, frame_done
  );

  modport slave (
    input  start, user_x, enemy_x, grid,
    output x, y, colour, plot, busy, frame_done
  );

endinterface

// File: rtl/display_scanner_scan_counter.sv
// scan_counter: raster x/y counter, x fastest; one step per enabled cycle, clear wins over enable.
// o_last flags the final pixel (W-1,H-1) combinationally so the caller can stop on it.
module scan_counter #(
  parameter int W  = 160,
  parameter int H  = 120,
  parameter int XW = $clog2(W),
  parameter int YW = $clog2(H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [XW-1:0] o_sx,
  output logic [YW-1:0] o_sy,
  output logic          o_last
);

  logic [XW-1:0] r_sx;
  logic [YW-1:0] r_sy;
  logic          w_x_end;
  logic          w_y_end;

  assign w_x_end = (r_sx == XW'(W - 1));
  assign w_y_end = (r_sy == YW'(H - 1));

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_sx <= '0;
      r_sy <= '0;
    end else if (i_en) begin
      if (w_x_end) begin
        r_sx <= '0;
        r_sy <= w_y_end ? '0 : r_sy + 1'b1;
      end else begin
        r_sx <= r_sx + 1'b1;
      end
    end
  end

  assign o_sx   = r_sx;
  assign o_sy   = r_sy;
  assign o_last = w_x_end && w_y_end;

endmodule

// File: rtl/display_scanner.sv
// display_scanner: one registered (x,y,colour) plot per cycle over a WxH frame, first plot 2 cycles after start.
// No backpressure (plots stream back to back); define DISPLAY_SHIP_SPRITE_EN for SHIP_W-wide ships.
module display_scanner
  import starflux_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int H      = DEF_H,
  parameter int SHIP_W = 5,
  parameter int XW     = $clog2(W),
  parameter int YW     = $clog2(H)
) (
  input logic             clk,
  input logic             reset,
  display_scanner_if.slave bus
);

  localparam int GW = $clog2(W * H);

  scan_state_t   r_state;
  scan_state_t   w_next;
  logic          r_drain;
  logic [XW-1:0] r_user_x;
  logic [XW-1:0] r_enemy_x;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [2:0]    r_colour;
  logic          r_plot;

  logic          w_clr;
  logic          w_en;
  logic [XW-1:0] w_sx;
  logic [YW-1:0] w_sy;
  logic          w_last;
  logic          w_user_col;
  logic          w_enemy_col;
  logic          w_user_hit;
  logic          w_enemy_hit;
  logic          w_grid_hit;
  logic [GW-1:0] w_gidx;
  logic [2:0]    w_pix;

  scan_counter #(
    .W (W),
    .H (H),
    .XW(XW),
    .YW(YW)
  ) u_scan_counter (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_clr),
    .i_en  (w_en),
    .o_sx  (w_sx),
    .o_sy  (w_sy),
    .o_last(w_last)
  );

  // r_drain holds SCAN one extra cycle so DONE lands after the last plot is visible.
  always_comb begin
    w_next = r_state;
    w_clr  = 1'b0;
    w_en   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_clr  = 1'b1;
          w_next = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (r_drain) begin
          w_next = ST_DONE;
        end else begin
          w_en = 1'b1;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

`ifdef DISPLAY_SHIP_SPRITE_EN
  // One extra bit keeps latched_x+SHIP_W from wrapping, so sprites clip at the right edge.
  assign w_user_col  = ({1'b0, w_sx} >= {1'b0, r_user_x}) &&
                       ({1'b0, w_sx} <  ({1'b0, r_user_x} + (XW+1)'(SHIP_W)));
  assign w_enemy_col = ({1'b0, w_sx} >= {1'b0, r_enemy_x}) &&
                       ({1'b0, w_sx} <  ({1'b0, r_enemy_x} + (XW+1)'(SHIP_W)));
`else
  assign w_user_col  = (w_sx == r_user_x);
  assign w_enemy_col = (w_sx == r_enemy_x);
`endif

  assign w_user_hit  = w_user_col && (w_sy == YW'(H - 1));
  assign w_enemy_hit = w_enemy_col && (w_sy == '0);
  assign w_gidx      = GW'(w_sy) * GW'(W) + GW'(w_sx);
  assign w_grid_hit  = bus.grid[w_gidx];

  always_comb begin
    w_pix = BLACK;
    if (w_user_hit) begin
      w_pix = RED;
    end else if (w_enemy_hit) begin
      w_pix = BLUE;
    end else if (w_grid_hit) begin
      w_pix = GREEN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_drain   <= 1'b0;
      r_user_x  <= '0;
      r_enemy_x <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_colour  <= '0;
      r_plot    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_drain <= w_en && w_last;
      r_plot  <= w_en;
      if (w_clr) begin
        r_user_x  <= bus.user_x;
        r_enemy_x <= bus.enemy_x;
      end
      if (w_en) begin
        r_x      <= w_sx;
        r_y      <= w_sy;
        r_colour <= w_pix;
      end
    end
  end

  assign bus.x          = r_x;
  assign bus.y          = r_y;
  assign bus.colour     = r_colour;
  assign bus.plot       = r_plot;
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.frame_done = (r_state == ST_DONE);

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner: expected plots are queued per frame at start and
// popped as the scanner emits them; handshake and reset behaviour checked inline.
module tb_display_scanner;
  import starflux_pkg::*;

  localparam int W      = 160;
  localparam int H      = 120;
  localparam int SHIP_W = 5;
  localparam int XW     = $clog2(W);
  localparam int YW     = $clog2(H);
  localparam int NPIX   = W * H;

  typedef logic [XW+YW+2:0] plot_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  display_scanner_if #(.W(W), .H(H)) ifc ();

  display_scanner #(
    .W     (W),
    .H     (H),
    .SHIP_W(SHIP_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc.slave)
  );

  plot_t          exp_q[$];
  logic [W*H-1:0] g;
  int vectors = 0;
  int errors  = 0;
  int cyc = 0;
  int plots_seen = 0;
  int done_seen = 0;
  int last_plot_cyc = 0;
  int done_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] model(input int px, input int py, input int ux, input int ex);
    logic uh, eh;
`ifdef DISPLAY_SHIP_SPRITE_EN
    uh = (py == H - 1) && (px >= ux) && (px < ux + SHIP_W);
    eh = (py == 0) && (px >= ex) && (px < ex + SHIP_W);
`else
    uh = (py == H - 1) && (px == ux);
    eh = (py == 0) && (px == ex);
`endif
    if (uh) return RED;
    if (eh) return BLUE;
    if (g[py*W + px]) return GREEN;
    return BLACK;
  endfunction

  // Advance one clock and sample just after the edge; every plot is scored here.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (ifc.plot === 1'b1) begin
      plots_seen++;
      last_plot_cyc = cyc;
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $error("FAIL extra_plot observed=(%0d,%0d) expected=none", ifc.x, ifc.y);
      end else begin
        plot_t e;
        e = exp_q.pop_front();
        check("plot_xyc", 32'({ifc.x, ifc.y, ifc.colour}), 32'(e));
      end
    end
    if (ifc.frame_done === 1'b1) begin
      done_seen++;
      done_cyc = cyc;
    end
  endtask

  task automatic start_frame(input int ux, input int ex);
    ifc.user_x  = XW'(ux);
    ifc.enemy_x = XW'(ex);
    ifc.grid    = g;
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++)
        exp_q.push_back({XW'(xx), YW'(yy), model(xx, yy, ux, ex)});
    plots_seen = 0;
    done_seen  = 0;
    ifc.start  = 1'b1;
    step();
    ifc.start  = 1'b0;
    check("busy_after_start", 32'(ifc.busy), 32'd1);
    check("no_plot_n1", 32'(ifc.plot), 32'd0);
    step();
    check("first_plot_n2", 32'(ifc.plot), 32'd1);
  endtask

  task automatic run_to_done(input int budget);
    int k;
    k = 0;
    while (done_seen == 0 && k < budget) begin
      step();
      k++;
    end
    if (done_seen == 0) begin
      vectors++;
      errors++;
      $error("FAIL done_timeout observed=no frame_done expected=frame_done within %0d cycles", budget);
    end
  endtask

  task automatic frame_end_checks(input string tag);
    check({tag, "_plots"}, 32'(plots_seen), 32'(NPIX));
    check({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_done_gap"}, 32'(done_cyc - last_plot_cyc), 32'd1);
    check({tag, "_busy_in_done"}, 32'(ifc.busy), 32'd1);
    check({tag, "_plot_in_done"}, 32'(ifc.plot), 32'd0);
    step();
    check({tag, "_done_pulse"}, 32'(ifc.frame_done), 32'd0);
    check({tag, "_idle_busy"}, 32'(ifc.busy), 32'd0);
    check({tag, "_done_count"}, 32'(done_seen), 32'd1);
  endtask

  initial begin
    reset       = 1'b1;
    ifc.start   = 1'b0;
    ifc.user_x  = '0;
    ifc.enemy_x = '0;
    g           = '0;
    ifc.grid    = '0;
    repeat (3) step();
    check("rst_plot", 32'(ifc.plot), 32'd0);
    check("rst_busy", 32'(ifc.busy), 32'd0);
    check("rst_done", 32'(ifc.frame_done), 32'd0);
    check("rst_xyc", 32'({ifc.x, ifc.y, ifc.colour}), 32'd0);
    reset = 1'b0;
    repeat (2) step();
    check("idle_no_plot", 32'(ifc.plot), 32'd0);

    // Frame interrupted by reset at pixel (40,10).
    start_frame(5, 100);
    begin
      int k;
      k = 0;
      while (plots_seen < 10*W + 41 && k < 3000) begin
        step();
        k++;
      end
    end
    check("a_reached_40_10", 32'({ifc.x, ifc.y}), 32'({XW'(40), YW'(10)}));
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_plot", 32'(ifc.plot), 32'd0);
    check("midrst_busy", 32'(ifc.busy), 32'd0);
    check("midrst_xyc", 32'({ifc.x, ifc.y, ifc.colour}), 32'd0);
    check("midrst_no_done", 32'(done_seen), 32'd0);
    exp_q.delete();
    repeat (2) step();

    // Empty grid; start pulses during SCAN and DONE must be ignored.
    start_frame(5, 100);
    repeat (500) step();
    ifc.start = 1'b1;
    repeat (3) step();
    ifc.start = 1'b0;
    run_to_done(NPIX + 100);
    ifc.start = 1'b1;
    frame_end_checks("b");
    ifc.start = 1'b0;
    repeat (5) step();
    check("b_ignored_busy", 32'(ifc.busy), 32'd0);
    check("b_ignored_plots", 32'(plots_seen), 32'(NPIX));
    check("b_ignored_done", 32'(done_seen), 32'd1);

    // Grid hits, one under the user ship; user_x changes mid-scan.
    g[(H-1)*W + 5] = 1'b1;
    g[7]           = 1'b1;
    start_frame(5, 100);
    repeat (100) step();
    ifc.user_x = XW'(20);
    run_to_done(NPIX + 100);
    frame_end_checks("c");
    repeat (2) step();

    start_frame(20, 100);
    run_to_done(NPIX + 100);
    frame_end_checks("d");
    repeat (2) step();

    // Ships near the right edge: sprites clip, single pixels stay at 157.
    start_frame(157, 157);
    run_to_done(NPIX + 100);
    frame_end_checks("e");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
